logic_axi4_stream_arbiter: RTL and testbench
============================================

Name: logic_axi4_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream consumer (typically the input of a queue instance) between INPUTS requester streams.
- Grant is locked to one requester from first beat until the tlast beat is accepted. It then rotates to the next valid requester.
- The output is registered, giving a full-throughput pipeline stage. Sits in front of the stream queue so several producers can share one buffer.

Parameters:
- INPUTS, 4, number of requester streams; must be >= 2 (DRC).
- INDEX_WIDTH, $clog2(INPUTS), width of the grant index.
- TID_WIDTH, 8, tx tid width used by the optional feature; must be >= INDEX_WIDTH (DRC when feature enabled).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  reset; synchronous, active-high.
- rx[INPUTS]  logic_axi4_stream_if.rx  bundle  requester streams: tvalid/tready/tlast plus payload.
- tx  logic_axi4_stream_if.tx  bundle  arbitrated output stream.

Behaviour:
- Reset: sampled on aclk edge while areset=1.
  - tx.tvalid=0; every rx[i].tready=0.
  - state=FSM_IDLE; pointer=INPUTS-1, so index 0 has first priority.
  - Reset mid-packet drops the packet in flight; no partial-packet recovery.
- States:
  - FSM_IDLE: no grant; all rx.tready=0.
    - If any rx[i].tvalid=1: select first valid index scanning pointer+1, pointer+2, ... modulo INPUTS (wrap-around).
    - Register grant=index, pointer=index, go to FSM_GRANT.
    - No valid requester: stay in FSM_IDLE.
  - FSM_GRANT:
    - rx[grant].tready = !tx.tvalid || tx.tready (combinational); all other rx.tready=0.
    - On rx[grant] handshake: load output register with rx[grant] payload, tlast included; tx.tvalid<=1.
    - No rx handshake but tx handshake: tx.tvalid<=0.
    - Simultaneous tx handshake and new rx handshake: register reloads; tx.tvalid stays 1 (no bubble).
    - rx[grant] handshake with tlast=1: next state FSM_IDLE.
- Latency:
  - rx.tvalid to grant: 1 cycle.
  - Accepted beat to tx.tvalid: 1 cycle.
  - Exactly one idle arbitration cycle on the rx side between consecutive packets. The tx side may stay continuous if the previous tlast beat is still registered.
- Fairness: after requester k finishes a packet, k has lowest priority in the next arbitration.
  - With all requesters continuously valid, grants cycle 0,1,2,...,INPUTS-1,0.
- Single-beat packet (tlast on first beat): one transfer, then FSM_IDLE.
- Grant held while rx[grant].tvalid=0 mid-packet; other requesters are blocked.
- tx payload is stable while tx.tvalid=1 and tx.tready=0 (AXI4-Stream rule).
- rx payload is ignored when rx.tready=0.

Optional Feature:
- Macro: LOGIC_AXI4_STREAM_ARBITER_TID_EN.
- Defined: tx.tid = zero-extended grant index, overriding rx tid, so downstream can demultiplex by source.
- Undefined: tx.tid = registered rx[grant].tid, unmodified passthrough.

Decomposition:
- Package logic_axi4_stream_arbiter_pkg:
  - state enum (FSM_IDLE, FSM_GRANT), 1-bit encoding.
  - function next_index(pointer, valid vector) returning the round-robin winner.
- Natural sub-module: logic_round_robin_arbiter.
  - Combinational request vector plus registered pointer produce a one-hot grant and index.
  - Updates pointer on a grant-enable input; reusable by other resource sharers.
- Output register stage inline.

Test Plan:
- Reset: assert areset for 3 cycles with all rx.tvalid=1 -> tx.tvalid=0 and all rx.tready=0 during reset; first grant after release is index 0.
- Round robin: all 4 requesters stream 2-beat packets, tx.tready=1 -> tx packets from sources 0,1,2,3,0,1; each packet contiguous; 1-cycle rx gap between packets.
- Packet lock: rx[2] sends 5-beat packet with tvalid gaps at beats 2 and 4 while rx[0] is valid -> all 5 beats of source 2 precede any beat of source 0.
- Backpressure: tx.tready low for 4 cycles mid-packet -> tx payload held stable; rx[grant].tready=0 while tx.tvalid=1 && !tx.tready; no beat lost or duplicated (scoreboard).
- Wrap/fairness: pointer=3, only rx[1] and rx[3] valid -> rx[1] granted before rx[3]; single-beat packets alternate 1,3,1,3.
- TID feature: with LOGIC_AXI4_STREAM_ARBITER_TID_EN, rx[3] sends tid=0xAA -> tx.tid=0x03; without macro -> tx.tid=0xAA.

Source files
------------

// File: rtl/logic_axi4_stream_arbiter_pkg.sv
// Shared types and the round-robin selection function for the stream arbiter.
// The FSM encoding is kept as plain 1-bit constants so older blocks can compare against them.
package logic_axi4_stream_arbiter_pkg;

  localparam int MAX_INPUTS   = 32;
  localparam int MAX_INDEX_W  = 5;

  typedef logic [0:0] state_t;
  localparam state_t FSM_IDLE  = 1'b0;
  localparam state_t FSM_GRANT = 1'b1;

  // Scan pointer+1, pointer+2, ... modulo inputs; the first set bit wins.
  // The caller only uses the result when at least one request bit is set.
  function automatic int next_index(input int pointer,
                                    input logic [MAX_INPUTS-1:0] request,
                                    input int inputs);
    int   idx;
    int   cand;
    logic found;
    idx   = pointer;
    found = 1'b0;
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      cand = (pointer + k) % inputs;
      if (!found && (k <= inputs) && request[cand[MAX_INDEX_W-1:0]]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle shared by the arbiter and its neighbours.
// A beat transfers on any rising edge where tvalid and tready are both 1; a source holds tvalid and payload until then.
interface logic_axi4_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TID_WIDTH  = 8
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [TID_WIDTH-1:0]  tid;

  modport rx (input tvalid, tlast, tdata, tid, output tready);
  modport tx (output tvalid, tlast, tdata, tid, input tready);
endinterface

// File: rtl/logic_round_robin_arbiter.sv
// Generic round-robin arbiter: combinational winner from a registered pointer.
// The pointer moves to the winner whenever grant_en is high and someone is requesting.
module logic_round_robin_arbiter
  import logic_axi4_stream_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [N-1:0]  request,
  input  logic          grant_en,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index,
  output logic          grant_any
);

  logic [IW-1:0] pointer;
  int            winner;

  always_comb begin
    winner       = next_index(int'(pointer), MAX_INPUTS'(request), N);
    grant_index  = IW'(winner);
    grant_any    = |request;
    grant_onehot = '0;
    if (grant_any) grant_onehot[grant_index] = 1'b1;
  end

  // Reset to the last index so index 0 gets first priority.
  always_ff @(posedge clk) begin
    if (areset) begin
      pointer <= IW'(N - 1);
    end else if (grant_en && grant_any) begin
      pointer <= grant_index;
    end
  end

endmodule

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one registered AXI4-Stream output between INPUTS sources.
// Define LOGIC_AXI4_STREAM_ARBITER_TID_EN to replace tx.tid with the zero-extended source index.
module logic_axi4_stream_arbiter
  import logic_axi4_stream_arbiter_pkg::*;
#(
  parameter int INPUTS      = 4,
  parameter int INDEX_WIDTH = $clog2(INPUTS),
  parameter int DATA_WIDTH  = 8,
  parameter int TID_WIDTH   = 8
) (
  input  logic            aclk,
  input  logic            areset,
  logic_axi4_stream_if.rx rx [INPUTS],
  logic_axi4_stream_if.tx tx,
  output state_t          dbg_state
);

  if (INPUTS < 2) begin : g_drc_inputs
    $error("logic_axi4_stream_arbiter: INPUTS must be >= 2");
  end

  logic [INPUTS-1:0]     rx_valid;
  logic [INPUTS-1:0]     rx_last;
  logic [INPUTS-1:0]     rx_ready;
  logic [DATA_WIDTH-1:0] rx_data [INPUTS];

  for (genvar i = 0; i < INPUTS; i++) begin : g_rx
    assign rx_valid[i]  = rx[i].tvalid;
    assign rx_last[i]   = rx[i].tlast;
    assign rx_data[i]   = rx[i].tdata;
    assign rx[i].tready = rx_ready[i];
  end

  state_t                 state;
  logic [INDEX_WIDTH-1:0] grant;
  logic [INPUTS-1:0]      grant_oh;
  logic [INPUTS-1:0]      arb_onehot;
  logic [INDEX_WIDTH-1:0] arb_index;
  logic                   arb_any;

  logic                   out_valid;
  logic                   out_last;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [TID_WIDTH-1:0]   out_tid;
  logic [TID_WIDTH-1:0]   tid_sel;
  logic                   accept_en;
  logic                   rx_hs;

  logic_round_robin_arbiter #(
    .N  (INPUTS),
    .IW (INDEX_WIDTH)
  ) u_rr (
    .clk          (aclk),
    .areset       (areset),
    .request      (rx_valid),
    .grant_en     (state == FSM_IDLE),
    .grant_onehot (arb_onehot),
    .grant_index  (arb_index),
    .grant_any    (arb_any)
  );

`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_EN
  if (TID_WIDTH < INDEX_WIDTH) begin : g_drc_tid
    $error("logic_axi4_stream_arbiter: TID_WIDTH must be >= INDEX_WIDTH");
  end
  assign tid_sel = TID_WIDTH'(grant);
`else
  logic [TID_WIDTH-1:0] rx_tid [INPUTS];
  for (genvar i = 0; i < INPUTS; i++) begin : g_tid
    assign rx_tid[i] = rx[i].tid;
  end
  assign tid_sel = rx_tid[grant];
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign accept_en = (state == FSM_GRANT) && (!out_valid || tx.tready);
  assign rx_ready  = accept_en ? grant_oh : '0;
  assign rx_hs     = accept_en && |(rx_valid & grant_oh);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= FSM_IDLE;
      grant     <= '0;
      grant_oh  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_tid   <= '0;
    end else begin
      if (state == FSM_IDLE) begin
        if (arb_any) begin
          grant    <= arb_index;
          grant_oh <= arb_onehot;
          state    <= FSM_GRANT;
        end
      end else if (rx_hs && rx_last[grant]) begin
        state <= FSM_IDLE;
      end

      if (rx_hs) begin
        out_valid <= 1'b1;
        out_data  <= rx_data[grant];
        out_last  <= rx_last[grant];
        out_tid   <= tid_sel;
      end else if (tx.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign tx.tvalid = out_valid;
  assign tx.tdata  = out_data;
  assign tx.tlast  = out_last;
  assign tx.tid    = out_tid;
  assign dbg_state = state;

endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Bench for logic_axi4_stream_arbiter: per-source packet queues, a round-robin packet-order model
// computed from the arbitration rules, and an expected-beat queue checked on every tx handshake.
module tb_logic_axi4_stream_arbiter;
  import logic_axi4_stream_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TW = 8;
  localparam int W  = TW + 1 + DW;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic          last;
    logic [DW-1:0] data;
    logic          gap;
  } beat_t;

  // clock / reset
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic_axi4_stream_if #(.DATA_WIDTH(DW), .TID_WIDTH(TW)) rx_if [N] ();
  logic_axi4_stream_if #(.DATA_WIDTH(DW), .TID_WIDTH(TW)) tx_if ();
  state_t dbg_state;

  logic [N-1:0]  rv, rl, rdy;
  logic [DW-1:0] rd [N];
  logic [TW-1:0] rt [N];
  logic          tx_ready;

  for (genvar g = 0; g < N; g++) begin : g_bind
    assign rx_if[g].tvalid = rv[g];
    assign rx_if[g].tlast  = rl[g];
    assign rx_if[g].tdata  = rd[g];
    assign rx_if[g].tid    = rt[g];
    assign rdy[g]          = rx_if[g].tready;
  end
  assign tx_if.tready = tx_ready;

  logic_axi4_stream_arbiter #(
    .INPUTS     (N),
    .DATA_WIDTH (DW),
    .TID_WIDTH  (TW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .rx        (rx_if),
    .tx        (tx_if),
    .dbg_state (dbg_state)
  );

  // source storage and model state
  beat_t        src_mem [N][DEPTH];
  int           head [N];
  int           tail [N];
  logic [N-1:0] held, gapped, mid;
  logic [W-1:0] exp_q [$];
  int           m_ptr;
  int           total, bad;
  int           cyc, phase_cyc, ready_mode, last_end;
  logic         gap_chk, prev_stall;
  logic [W-1:0] prev_word;
  string        ph;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input logic [TW-1:0] tid, input int gap_mask);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data = DW'($urandom);
      x.tid  = tid;
      x.last = (b == len - 1);
      x.gap  = (b > 0) && gap_mask[b];
      src_mem[s][tail[s]] = x;
      tail[s]++;
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < N; s++) n += tail[s] - head[s];
    return n;
  endfunction

  // Packet order: repeatedly pick the first source after the last winner that still has a packet.
  function automatic void build_expected();
    int    left [N];
    int    rdp [N];
    int    remaining;
    int    s;
    beat_t x;
    logic [TW-1:0] tid_exp;
    remaining = 0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      rdp[i]  = head[i];
      for (int j = head[i]; j < tail[i]; j++) if (src_mem[i][j].last) left[i]++;
      remaining += left[i];
    end
    while (remaining > 0) begin
      s = -1;
      for (int k = 1; k <= N; k++) begin
        if (s < 0 && left[(m_ptr + k) % N] > 0) s = (m_ptr + k) % N;
      end
      do begin
        x = src_mem[s][rdp[s]];
        rdp[s]++;
`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_EN
        tid_exp = TW'(s);
`else
        tid_exp = x.tid;
`endif
        exp_q.push_back({tid_exp, x.last, x.data});
      end while (!x.last);
      left[s]--;
      remaining--;
      m_ptr = s;
    end
  endfunction

  // driver: one cycle, starting and ending at a falling edge
  task automatic cycle();
    beat_t        x;
    logic         txv;
    logic [W-1:0] txw;
    logic [N-1:0] rdyv;
    for (int g = 0; g < N; g++) begin
      rd[g] = DW'($urandom);
      rl[g] = 1'($urandom);
      rt[g] = TW'($urandom);
      rv[g] = 1'b0;
      if (head[g] != tail[g]) begin
        x = src_mem[g][head[g]];
        if (!held[g] && x.gap && !gapped[g]) begin
          gapped[g] = 1'b1;
        end else begin
          rv[g] = 1'b1;
          rd[g] = x.data;
          rl[g] = x.last;
          rt[g] = x.tid;
        end
      end
    end
    case (ready_mode)
      1:       tx_ready = ($urandom_range(0, 9) < 6);
      2:       tx_ready = !(phase_cyc >= 3 && phase_cyc <= 6);
      default: tx_ready = 1'b1;
    endcase

    #4;
    rdyv = rdy;
    txv  = tx_if.tvalid;
    txw  = {tx_if.tid, tx_if.tlast, tx_if.tdata};
    if (areset) begin
      check("rst_tvalid", 32'(txv), 0);
      check("rst_tready", 32'(rdyv), 0);
      check("rst_state", 32'(dbg_state), 32'(FSM_IDLE));
    end else begin
      check("rdy_onehot", 32'($countones(rdyv) <= 1), 1);
      if (txv && !tx_ready) check("bp_tready", 32'(rdyv), 0);
      if (prev_stall) begin
        check("hold_valid", 32'(txv), 1);
        check("hold_word", 32'(txw), 32'(prev_word));
      end
      for (int g = 0; g < N; g++) begin
        if (rv[g] && rdyv[g]) begin
          x = src_mem[g][head[g]];
          if (gap_chk && !mid[g]) check("rr_gap", cyc - last_end, 2);
          if (x.last) last_end = cyc;
          mid[g]    = !x.last;
          head[g]++;
          held[g]   = 1'b0;
          gapped[g] = 1'b0;
        end else begin
          held[g] = rv[g];
        end
      end
      if (txv && tx_ready) begin
        if (exp_q.size() == 0) check("tx_extra", exp_q.size(), 1);
        else check({ph, "_beat"}, 32'(txw), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = !areset && txv && !tx_ready;
    prev_word  = txw;
    @(negedge aclk);
    cyc++;
    phase_cyc++;
  endtask

  task automatic clear_sources();
    for (int s = 0; s < N; s++) begin
      head[s] = 0;
      tail[s] = 0;
    end
  endtask

  task automatic run_phase(input string name, input int mode, input int budget);
    int n;
    ph         = name;
    ready_mode = mode;
    phase_cyc  = 0;
    build_expected();
    n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, exp_q.size() + pending(), 0);
    exp_q.delete();
    clear_sources();
    repeat (2) cycle();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; phase_cyc = 0; ready_mode = 0;
    held = '0; gapped = '0; mid = '0; gap_chk = 1'b0; prev_stall = 1'b0; prev_word = '0;
    last_end = 0; m_ptr = N - 1; ph = "reset";
    rv = '0; rl = '0; tx_ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      rd[s] = '0;
      rt[s] = '0;
    end
    clear_sources();

    // round robin: every source valid through reset, 2-beat packets
    add_pkt(0, 2, 8'h10, 0); add_pkt(0, 2, 8'h11, 0);
    add_pkt(1, 2, 8'h20, 0); add_pkt(1, 2, 8'h21, 0);
    add_pkt(2, 2, 8'h30, 0);
    add_pkt(3, 2, 8'h40, 0);
    @(negedge aclk);
    repeat (3) cycle();
    areset   = 1'b0;
    last_end = cyc - 1;
    gap_chk  = 1'b1;
    run_phase("rr", 0, 200);
    gap_chk  = 1'b0;

    // packet lock: source 2 with valid gaps at beats 2 and 4, source 0 waiting
    add_pkt(2, 5, 8'h52, 'b1010);
    add_pkt(0, 2, 8'h50, 0);
    run_phase("lock", 0, 200);

    // backpressure: tx.tready low for 4 cycles mid-packet
    add_pkt(1, 6, 8'h61, 0);
    run_phase("stall", 2, 200);

    // randomized traffic with random backpressure and valid gaps
    for (int it = 0; it < 4; it++) begin
      for (int s = 0; s < N; s++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--)
          add_pkt(s, $urandom_range(1, 4), TW'($urandom), int'($urandom));
      end
      run_phase("rand", 1, 800);
    end

    // tid handling, which also leaves the pointer at 3
    add_pkt(3, 1, 8'hAA, 0);
    run_phase("tid", 0, 100);

    // wrap: only sources 1 and 3, single-beat packets
    add_pkt(1, 1, 8'h71, 0); add_pkt(1, 1, 8'h72, 0);
    add_pkt(3, 1, 8'h73, 0); add_pkt(3, 1, 8'h74, 0);
    run_phase("wrap", 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
